irq_controller: RTL

Memory-mapped interrupt controller between external device interrupt lines and the CP0 `HWInt` input. Synchronises each raw source, applies per-source level/edge mode and mask, and holds pending state. Drives a registered, masked request vector to CP0. Software reads a priority-encoded claim register from the handler to pick and acknowledge one source; the CPU reaches the controller through the system bridge.

---
 rtl/irq_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// irq_controller : synchronised level/edge interrupt sources, masked into CP0 HWInt
// Revision 1.0
// ============================================================================
module irq_controller #(
  parameter int NSRC        = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            sel,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [5:0]      HWInt
);

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_MASK  = 2'd1;
  localparam logic [1:0] A_MODE  = 2'd2;
  localparam logic [1:0] A_CLAIM = 2'd3;

  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] act;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] claim_hot;
  logic [2:0]      claim_id;
  logic            any_act;
  logic [31:0]     claim_val;
  logic            wr_pend;
  logic            wr_mask;
  logic            wr_mode;
  logic            rd_claim;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:NSRC];

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign act  = pend & mask;

  assign wr_pend  = sel & we & (addr == A_PEND);
  assign wr_mask  = sel & we & (addr == A_MASK);
  assign wr_mode  = sel & we & (addr == A_MODE);
  assign rd_claim = sel & ~we & (addr == A_CLAIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_irq};
      s_d    <= s;
    end
  end

  // Lowest-numbered active source wins the claim.
  always_comb begin
    claim_id  = '0;
    claim_hot = '0;
    any_act   = |act;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) claim_id = 3'(i);
    end
    for (int i = 0; i < NSRC; i++) begin
      claim_hot[i] = any_act && (claim_id == 3'(i));
    end
    claim_val = any_act ? {23'd0, 1'b1, 5'd0, claim_id} : 32'd0;
  end

  // Clears only matter for edge-mode bits; a simultaneous rise takes priority.
  always_comb begin
    clr      = (wr_pend ? wdata[NSRC-1:0] : '0) | (rd_claim ? claim_hot : '0);
    pend_nxt = (mode & (rise | (pend & ~clr))) | (~mode & s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      HWInt <= '0;
    end else begin
      pend  <= pend_nxt;
      HWInt <= 6'(act);
      if (wr_mask) mask <= wdata[NSRC-1:0];
      if (wr_mode) mode <= wdata[NSRC-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        A_PEND:  rdata = 32'(pend);
        A_MASK:  rdata = 32'(mask);
        A_MODE:  rdata = 32'(mode);
        A_CLAIM: rdata = claim_val;
        default: rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
